coef_row_arbiter: RTL and testbench

//  Shares one coefficient row path (row_buffer plus the row IDCT stage behind it) between NUM_REQ coefficient producers, e.g. Y/Cb/Cr.

---
 rtl/coef_row_arbiter_pkg.sv | 19 +
 rtl/coef_row_arbiter_if.sv | 32 +++
 rtl/coef_row_arbiter_rr_priority_picker.sv | 32 +++
 rtl/coef_row_arbiter.sv | 114 +++++++++++
 tb/tb_coef_row_arbiter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/coef_row_arbiter_pkg.sv
// coef_row_arbiter_pkg
//   Shared types and defaults for the coefficient row arbiter.
//   COEF_W / ROW_LEN : default coefficient width and beats per row grant.
//   coef_t           : one coefficient, two's complement.
//   arb_state_t      : arbiter FSM states.
//   id_width()       : requester-id width, never below 1 bit.
package coef_row_arbiter_pkg;
  localparam int NUM_REQ_DEF = 3;
  localparam int COEF_W      = 11;
  localparam int ROW_LEN     = 8;

  typedef logic signed [COEF_W-1:0] coef_t;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/coef_row_arbiter_if.sv
// coef_row_arbiter_if
//   Bundles the requester side (valid/ena/rdy/data per requester) and the
//   downstream side (ena_out/rdy_in/out/out_id/out_last) of the arbiter.
//   slave  : arbiter view.
//   master : producer/consumer (environment) view.
interface coef_row_arbiter_if
  import coef_row_arbiter_pkg::id_width;
#(
  parameter int NUM_REQ = 3,
  parameter int COEF_W  = 11,
  parameter int ID_W    = id_width(NUM_REQ)
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ena_in;
  logic [NUM_REQ-1:0]             req_rdy_out;
  logic [NUM_REQ-1:0][COEF_W-1:0] req_in;
  logic                           ena_out;
  logic                           rdy_in;
  logic [COEF_W-1:0]              out;
  logic [ID_W-1:0]                out_id;
  logic                           out_last;

  modport slave (
    input  req_valid, req_ena_in, req_in, rdy_in,
    output req_rdy_out, ena_out, out, out_id, out_last
  );

  modport master (
    output req_valid, req_ena_in, req_in, rdy_in,
    input  req_rdy_out, ena_out, out, out_id, out_last
  );
endinterface

// File: rtl/coef_row_arbiter_rr_priority_picker.sv
// rr_priority_picker
//   Combinational round-robin search: first set bit of i_req at or after
//   i_ptr, wrapping around.
//   i_req : request vector      i_ptr : starting index
//   o_any : some request set    o_idx : chosen index (0 when none)
module rr_priority_picker
  import coef_row_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic               o_any,
  output logic [ID_W-1:0]    o_idx
);
  logic [ID_W-1:0] w_cand;

  always_comb begin
    o_any  = 1'b0;
    o_idx  = '0;
    w_cand = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = (int'(i_ptr) + k >= NUM_REQ) ? ID_W'(int'(i_ptr) + k - NUM_REQ)
                                            : ID_W'(int'(i_ptr) + k);
      if (!o_any && i_req[w_cand]) begin
        o_any = 1'b1;
        o_idx = w_cand;
      end
    end
  end
endmodule

// File: rtl/coef_row_arbiter.sv
// coef_row_arbiter
//   Shares one coefficient row path between NUM_REQ producers. Grants whole
//   rows of ROW_LEN beats atomically, round-robin, and tags each beat with
//   the source id and a last-of-row flag.
//   clk, rst   : clock, async active-high reset
//   bus        : coef_row_arbiter_if.slave (requester + downstream handshakes)
//   stat_rows  : per-requester completed-row counters (16 bit, wrapping),
//                present only when COEF_ROW_ARB_STATS_EN is defined.
module coef_row_arbiter
  import coef_row_arbiter_pkg::arb_state_t;
  import coef_row_arbiter_pkg::IDLE;
  import coef_row_arbiter_pkg::BUSY;
  import coef_row_arbiter_pkg::id_width;
#(
  parameter int NUM_REQ = coef_row_arbiter_pkg::NUM_REQ_DEF,
  parameter int COEF_W  = coef_row_arbiter_pkg::COEF_W,
  parameter int ROW_LEN = coef_row_arbiter_pkg::ROW_LEN
) (
  input  logic                       clk,
  input  logic                       rst,
  coef_row_arbiter_if.slave          bus
`ifdef COEF_ROW_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][15:0]   stat_rows
`endif
);
  localparam int ID_W   = id_width(NUM_REQ);
  localparam int BEAT_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;

  arb_state_t        r_state, w_state_nx;
  logic [ID_W-1:0]   r_grant, w_grant_nx;
  logic [BEAT_W-1:0] r_beat,  w_beat_nx;
  logic [ID_W-1:0]   r_rr_ptr, w_rr_ptr_nx;

  logic              w_xfer, w_row_end;
  logic [ID_W-1:0]   w_next_ptr, w_pick_ptr, w_pick_idx;
  logic              w_pick_any;

  assign w_xfer     = (r_state == BUSY) && bus.req_ena_in[r_grant];
  assign w_row_end  = w_xfer && (r_beat == BEAT_W'(ROW_LEN - 1));
  assign w_next_ptr = (r_grant == ID_W'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
  // In BUSY the picker only matters at end of row, where it must already
  // search from the advanced pointer so the next row follows with no bubble.
  assign w_pick_ptr = (r_state == BUSY) ? w_next_ptr : r_rr_ptr;

  rr_priority_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .i_req (bus.req_valid),
    .i_ptr (w_pick_ptr),
    .o_any (w_pick_any),
    .o_idx (w_pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_beat   <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_grant  <= w_grant_nx;
      r_beat   <= w_beat_nx;
      r_rr_ptr <= w_rr_ptr_nx;
    end
  end

  always_comb begin
    w_state_nx      = r_state;
    w_grant_nx      = r_grant;
    w_beat_nx       = r_beat;
    w_rr_ptr_nx     = r_rr_ptr;
    bus.req_rdy_out = '0;
    bus.ena_out     = 1'b0;
    bus.out         = '0;
    bus.out_id      = '0;
    bus.out_last    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_state_nx = BUSY;
          w_grant_nx = w_pick_idx;
          w_beat_nx  = '0;
        end
      end
      BUSY: begin
        bus.req_rdy_out[r_grant] = bus.rdy_in;
        bus.ena_out              = bus.req_ena_in[r_grant];
        bus.out                  = bus.req_in[r_grant];
        bus.out_id               = r_grant;
        bus.out_last             = (r_beat == BEAT_W'(ROW_LEN - 1));
        if (w_row_end) begin
          w_beat_nx   = '0;
          w_rr_ptr_nx = w_next_ptr;
          if (w_pick_any) w_grant_nx = w_pick_idx;
          else            w_state_nx = IDLE;
        end else if (w_xfer) begin
          w_beat_nx = r_beat + 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

`ifdef COEF_ROW_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] r_stat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_stat <= '0;
    else if (w_row_end) r_stat[r_grant] <= r_stat[r_grant] + 16'd1;
  end

  assign stat_rows = r_stat;
`endif
endmodule

// File: tb/tb_coef_row_arbiter.sv
// tb_coef_row_arbiter
//   Directed bench for coef_row_arbiter (NUM_REQ=3, COEF_W=11, ROW_LEN=8).
//   Producers raise ena only while their rdy is high (ena = mask & rdy_out).
//   Observed bundle per cycle: {ena_out, req_rdy_out, out_id, out_last, out}.
module tb_coef_row_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0]       vld, mask;
  logic             rdy;
  logic [2:0][10:0] din;

  coef_row_arbiter_if #(.NUM_REQ(3), .COEF_W(11)) ifc();

  assign ifc.req_valid  = vld;
  assign ifc.req_ena_in = mask & ifc.req_rdy_out;
  assign ifc.req_in     = din;
  assign ifc.rdy_in     = rdy;

`ifdef COEF_ROW_ARB_STATS_EN
  logic [2:0][15:0] stat_rows;
`endif

  coef_row_arbiter #(.NUM_REQ(3), .COEF_W(11), .ROW_LEN(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (ifc.slave)
`ifdef COEF_ROW_ARB_STATS_EN
    ,
    .stat_rows (stat_rows)
`endif
  );

  wire [17:0] got = {ifc.ena_out, ifc.req_rdy_out, ifc.out_id, ifc.out_last, ifc.out};

  // Protocol checks on both sides of the arbiter.
  always @(posedge clk) begin
    if (!rst) begin
      assert ((ifc.req_ena_in & ~ifc.req_rdy_out) == 3'b000)
        else $error("req_ena_in raised without req_rdy_out");
      assert (!(ifc.ena_out && !ifc.rdy_in))
        else $error("ena_out raised without rdy_in");
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; vld = '0; mask = '0; rdy = 1'b1; din = '0;
    step; step;
    rst = 1'b0;
  endtask

  task automatic set_din(input int k);
    for (int i = 0; i < 3; i++) din[i] = 11'(i * 16 + k);
  endtask

  task automatic test_reset;
    rst = 1'b1; vld = 3'b111; mask = 3'b111; rdy = 1'b1; din = '1;
    for (int c = 0; c < 2; c++) begin
      step; #1;
      n_tests++;
      if (got !== 18'd0) begin
        n_fail++;
        $display("FAIL reset_outputs c%0d: got %h expected %h", c, got, 18'd0);
      end
    end
  endtask

  task automatic test_single_row;
    logic [10:0] tbl [0:7];
    logic [17:0] exp;
    tbl = '{11'h400, 11'd1, 11'd2, 11'd3, 11'd4, 11'd5, 11'd6, 11'd7};
    do_reset;
    vld = 3'b010; mask = 3'b010; rdy = 1'b1;
    #1; n_tests++;
    if (got !== 18'd0) begin
      n_fail++; $display("FAIL single_idle: got %h expected %h", got, 18'd0);
    end
    step;
    for (int k = 0; k < 8; k++) begin
      din[1] = tbl[k];
      if (k == 7) vld = 3'b000;
      exp = {1'b1, 3'b010, 2'd1, (k == 7), tbl[k]};
      #1; n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL single_beat%0d: got %h expected %h", k, got, exp);
      end
      step;
    end
    #1; n_tests++;
    if (got !== 18'd0) begin
      n_fail++; $display("FAIL single_after: got %h expected %h", got, 18'd0);
    end
  endtask

  task automatic test_back_to_back;
    logic [17:0] exp;
    int g;
    do_reset;
    vld = 3'b111; mask = 3'b111; rdy = 1'b1;
    step;
    for (int r = 0; r < 4; r++) begin
      g = r % 3;
      for (int k = 0; k < 8; k++) begin
        set_din(k);
        if (r == 3 && k == 7) vld = 3'b000;
        exp = {1'b1, 3'(1 << g), 2'(g), (k == 7), 11'(g * 16 + k)};
        #1; n_tests++;
        if (got !== exp) begin
          n_fail++; $display("FAIL rr_row%0d_beat%0d: got %h expected %h", r, k, got, exp);
        end
        step;
      end
    end
    #1; n_tests++;
    if (got !== 18'd0) begin
      n_fail++; $display("FAIL rr_after: got %h expected %h", got, 18'd0);
    end
  endtask

  task automatic test_stall;
    logic [17:0] exp;
    do_reset;
    vld = 3'b100; mask = 3'b100; rdy = 1'b1;
    step;
    for (int k = 0; k < 3; k++) begin
      din[2] = 11'(32 + k);
      if (k == 0) vld = 3'b000;
      exp = {1'b1, 3'b100, 2'd2, 1'b0, 11'(32 + k)};
      #1; n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL stall_pre%0d: got %h expected %h", k, got, exp);
      end
      step;
    end
    for (int s = 0; s < 5; s++) begin
      rdy = 1'b0; din[2] = 11'd35;
      exp = {1'b0, 3'b000, 2'd2, 1'b0, 11'd35};
      #1; n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL stall_hold%0d: got %h expected %h", s, got, exp);
      end
      step;
    end
    for (int k = 3; k < 8; k++) begin
      rdy = 1'b1; din[2] = 11'(32 + k);
      exp = {1'b1, 3'b100, 2'd2, (k == 7), 11'(32 + k)};
      #1; n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL stall_post%0d: got %h expected %h", k, got, exp);
      end
      step;
    end
    #1; n_tests++;
    if (got !== 18'd0) begin
      n_fail++; $display("FAIL stall_after: got %h expected %h", got, 18'd0);
    end
  endtask

  task automatic test_valid_drop;
    logic [17:0] exp;
    do_reset;
    vld = 3'b100; mask = 3'b111; rdy = 1'b1;
    step;
    for (int k = 0; k < 8; k++) begin
      set_din(k);
      if (k == 2) vld = 3'b001;
      exp = {1'b1, 3'b100, 2'd2, (k == 7), 11'(32 + k)};
      #1; n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL drop_beat%0d: got %h expected %h", k, got, exp);
      end
      step;
    end
    set_din(0); vld = 3'b000;
    exp = {1'b1, 3'b001, 2'd0, 1'b0, 11'd0};
    #1; n_tests++;
    if (got !== exp) begin
      n_fail++; $display("FAIL drop_next_row: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_reset_mid_row;
    logic [17:0] exp;
    do_reset;
    vld = 3'b010; mask = 3'b111; rdy = 1'b1;
    step;
    for (int k = 0; k < 8; k++) begin
      set_din(k);
      if (k == 7) vld = 3'b100;
      step;
    end
    for (int k = 0; k < 5; k++) begin
      set_din(k);
      exp = {1'b1, 3'b100, 2'd2, 1'b0, 11'(32 + k)};
      #1; n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL midrst_pre%0d: got %h expected %h", k, got, exp);
      end
      if (k < 4) step;
    end
    rst = 1'b1;
    #1; n_tests++;
    if (got !== 18'd0) begin
      n_fail++; $display("FAIL midrst_async: got %h expected %h", got, 18'd0);
    end
    step;
    rst = 1'b0; vld = 3'b110; set_din(0);
    #1; n_tests++;
    if (got !== 18'd0) begin
      n_fail++; $display("FAIL midrst_idle: got %h expected %h", got, 18'd0);
    end
    step;
    exp = {1'b1, 3'b010, 2'd1, 1'b0, 11'd16};
    #1; n_tests++;
    if (got !== exp) begin
      n_fail++; $display("FAIL midrst_regrant: got %h expected %h", got, exp);
    end
  endtask

`ifdef COEF_ROW_ARB_STATS_EN
  task automatic test_stats;
    logic [2:0][15:0] exp;
    do_reset;
    vld = 3'b010; mask = 3'b010; rdy = 1'b1;
    step;
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 8; k++) begin
        set_din(k);
        if (r == 4 && k == 7) vld = 3'b000;
        step;
      end
    end
    exp = {16'd0, 16'd5, 16'd0};
    n_tests++;
    if (stat_rows !== exp) begin
      n_fail++; $display("FAIL stats_five: got %h expected %h", stat_rows, exp);
    end
    force dut.r_stat = {16'd0, 16'hFFFF, 16'd0};
    step;
    release dut.r_stat;
    vld = 3'b010;
    step;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) vld = 3'b000;
      step;
    end
    exp = '0;
    n_tests++;
    if (stat_rows !== exp) begin
      n_fail++; $display("FAIL stats_wrap: got %h expected %h", stat_rows, exp);
    end
  endtask
`endif

  initial begin
    vld = '0; mask = '0; rdy = 1'b0; din = '0;
    test_reset;
    test_single_row;
    test_back_to_back;
    test_stall;
    test_valid_drop;
    test_reset_mid_row;
`ifdef COEF_ROW_ARB_STATS_EN
    test_stats;
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
